uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 145 ++++++++++++++
 tb/tb_uart_rx_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: byte FIFO between a UART receiver and a consumer.
// Captures one byte per rising edge of rx_complete, presents the head
// byte show-ahead, drives hysteretic RTS flow control from the fill level,
// and tracks dropped bytes with a sticky flag and a saturating counter.
//
// Handshake: the consumer side is valid/ready. out_data is meaningful only
// while out_valid is high; a byte is consumed on every rising clk100 edge
// where out_valid and out_ready are both high, and out_valid never depends
// on out_ready.
module uart_rx_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_HIGH   = 12,
    parameter int RTS_LOW    = 4
) (
    input  logic                  clk100,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_complete,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  rts_n,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    input  logic                  clear_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [LW-1:0]         DEPTH_L    = LW'(DEPTH);
    localparam logic [LW-1:0]         RTS_HIGH_L = LW'(RTS_HIGH);
    localparam logic [LW-1:0]         RTS_LOW_L  = LW'(RTS_LOW);
    localparam logic [LW-1:0]         LVL_ONE    = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [7:0]            DROP_MAX   = 8'hFF;

    // Flow-control state; rts_n is this state bit directly, so it is registered.
    typedef enum logic {
        FLOW_ON  = 1'b0,
        FLOW_OFF = 1'b1
    } flow_state_t;

    flow_state_t             flow_q, flow_d;
    logic                    rx_complete_d_q, rx_complete_d_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic [7:0]              drop_count_q, drop_count_d;
    logic [7:0]              mem_q [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    // Edge detect, FIFO bookkeeping and drop accounting.
    always_comb begin
        rx_complete_d_d = rx_complete;
        push            = rx_complete & ~rx_complete_d_q;
        full            = (level_q == DEPTH_L);
        out_valid       = (level_q != '0);
        pop             = out_valid & out_ready;
        // A push while full still fits if the head leaves on the same edge.
        accept          = push & (~full | pop);
        drop            = push & full & ~pop;

        wr_ptr_d = accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop    ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        level_d = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            // A drop outranks a simultaneous clear: the new drop is counted fresh.
            overflow_d   = 1'b1;
            if (clear_overflow) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != DROP_MAX) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // Hysteretic flow control driven by the registered level.
    always_comb begin
        flow_d = flow_q;
        case (flow_q)
            FLOW_ON:  if (level_q >= RTS_HIGH_L) flow_d = FLOW_OFF;
            FLOW_OFF: if (level_q <= RTS_LOW_L)  flow_d = FLOW_ON;
            default:  flow_d = FLOW_ON;
        endcase
    end

    // Control state with asynchronous reset; rx_complete_d resets high so a
    // strobe already high at reset release is not mistaken for a new byte.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            rx_complete_d_q <= 1'b1;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            overflow_q      <= 1'b0;
            drop_count_q    <= 8'd0;
            flow_q          <= FLOW_ON;
        end else begin
            rx_complete_d_q <= rx_complete_d_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            overflow_q      <= overflow_d;
            drop_count_q    <= drop_count_d;
            flow_q          <= flow_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk100) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Output mapping; the head byte is read combinationally (show-ahead).
    always_comb begin
        out_data   = mem_q[rd_ptr_q];
        rts_n      = (flow_q == FLOW_OFF);
        level      = level_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Testbench for uart_rx_buffer: a table of per-cycle vectors for the basic
// push/pop behaviour, then hand-written sequences for flow control,
// overflow, full-FIFO push/pop and asynchronous reset.
module tb_uart_rx_buffer;

    logic       clk100;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       rts_n;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_overflow;

    int errors;
    int checks;

    logic [7:0] exp_q[$];

    uart_rx_buffer dut (
        .clk100         (clk100),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_complete    (rx_complete),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .rts_n          (rts_n),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    // Clock and reset
    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    typedef struct {
        logic       rxc;
        logic [7:0] data;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        int         e_level;
        logic       e_rts;
        logic       e_ovf;
        int         e_drop;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic clr);
        rx_data        = b;
        rx_complete    = 1'b1;
        clear_overflow = clr;
        tick();
        rx_complete    = 1'b0;
        clear_overflow = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        tick();
    endtask

    // Drain everything, comparing each head byte against the expected queue.
    task automatic drain_check(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_valid"}, int'(out_valid), 1);
            chk({name, "_data"}, int'(out_data), int'(e));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk({name, "_level_end"}, int'(level), 0);
        chk({name, "_valid_end"}, int'(out_valid), 0);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        rx_data        = 8'h00;
        rx_complete    = 1'b1;   // held high across reset release
        out_ready      = 1'b0;
        clear_overflow = 1'b0;

        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h41, 2, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 1, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};

        // Reset state, with rx_complete high through the release.
        #12;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_rts_n", int'(rts_n), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drop", int'(drop_count), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("held_strobe_level", int'(level), 0);
        chk("held_strobe_valid", int'(out_valid), 0);

        // Table: two-byte push/pop, then a 5-cycle strobe that stores once.
        for (int i = 0; i < 13; i++) begin
            rx_complete    = vecs[i].rxc;
            rx_data        = vecs[i].data;
            out_ready      = vecs[i].rdy;
            clear_overflow = vecs[i].clr;
            tick();
            chk($sformatf("v%0d_valid", i), int'(out_valid), int'(vecs[i].e_valid));
            if (vecs[i].e_valid)
                chk($sformatf("v%0d_data", i), int'(out_data), int'(vecs[i].e_data));
            chk($sformatf("v%0d_level", i), int'(level), vecs[i].e_level);
            chk($sformatf("v%0d_rts_n", i), int'(rts_n), int'(vecs[i].e_rts));
            chk($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].e_ovf));
            chk($sformatf("v%0d_drop", i), int'(drop_count), vecs[i].e_drop);
        end
        rx_complete = 1'b0;
        out_ready   = 1'b0;

        // Flow control thresholds and hysteresis.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rx_data     = 8'h60 + 8'(i);
            rx_complete = 1'b1;
            tick();
            if (i == 11) begin
                chk("flow_level12", int'(level), 12);
                chk("flow_rts_lag", int'(rts_n), 0);
            end
            rx_complete = 1'b0;
            tick();
            if (i == 11) chk("flow_rts_off", int'(rts_n), 1);
        end
        for (int i = 0; i < 7; i++) begin
            chk("flow_pop_data", int'(out_data), 'h60 + i);
            out_ready = 1'b1;
            tick();
        end
        chk("flow_level5", int'(level), 5);
        chk("flow_rts_at5", int'(rts_n), 1);
        tick();
        out_ready = 1'b0;
        chk("flow_level4", int'(level), 4);
        chk("flow_rts_lag4", int'(rts_n), 1);
        tick();
        chk("flow_rts_on", int'(rts_n), 0);

        // Overflow: 18 pushes, saturation, clear priority, in-order readback.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            push_byte(8'h10 + 8'(i), 1'b0);
            if (i < 16) exp_q.push_back(8'h10 + 8'(i));
        end
        chk("ovf_level", int'(level), 16);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_drop2", int'(drop_count), 2);
        for (int i = 0; i < 260; i++) push_byte(8'hEE, 1'b0);
        chk("ovf_drop_sat", int'(drop_count), 255);
        push_byte(8'hEE, 1'b1);
        chk("ovf_clr_drop_flag", int'(overflow), 1);
        chk("ovf_clr_drop_cnt", int'(drop_count), 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_clear_flag", int'(overflow), 0);
        chk("ovf_clear_cnt", int'(drop_count), 0);
        chk("ovf_clear_level", int'(level), 16);
        drain_check("ovf_read");

        // Full FIFO: simultaneous push and pop is accepted.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h20 + 8'(i), 1'b0);
            if (i > 0) exp_q.push_back(8'h20 + 8'(i));
        end
        exp_q.push_back(8'hAA);
        chk("full_level", int'(level), 16);
        rx_data     = 8'hAA;
        rx_complete = 1'b1;
        out_ready   = 1'b1;
        tick();
        rx_complete = 1'b0;
        out_ready   = 1'b0;
        chk("full_pp_level", int'(level), 16);
        chk("full_pp_ovf", int'(overflow), 0);
        tick();
        drain_check("full_read");

        // Asynchronous reset mid-operation at level 7 with rts_n high.
        do_reset();
        for (int i = 0; i < 12; i++) push_byte(8'h70 + 8'(i), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        chk("ar_level7", int'(level), 7);
        chk("ar_rts_pre", int'(rts_n), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_level", int'(level), 0);
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_rts_n", int'(rts_n), 0);
        tick();
        reset = 1'b0;
        tick();
        push_byte(8'h99, 1'b0);
        chk("ar_push_level", int'(level), 1);
        chk("ar_push_head", int'(out_data), 'h99);
        chk("ar_wr_addr0", int'(dut.mem_q[0]), 'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
